pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control sequencer: turns stall/flush/HLT requests into PC, IF/ID and ID/EX controls
// and owns the halt drain. Optional performance counters are enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int DRAIN_DEPTH = 3,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall_req,
  input  logic flush_req,
  input  logic hlt_dec,
  output logic pc_wen,
  output logic if_id_wen,
  output logic if_id_flush,
  output logic id_ex_flush,
  output logic drain_busy,
  output logic halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } st_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_DEPTH);

  st_t        st_reg;
  logic [3:0] drain_cnt_reg;

  // drain_cnt counts remaining retire edges; reaching 1 means the next edge halts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_reg        <= RUN;
      drain_cnt_reg <= '0;
    end else begin
      case (st_reg)
        RUN: begin
          if (!flush_req && hlt_dec) begin
            st_reg        <= DRAIN;
            drain_cnt_reg <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (flush_req) begin
            st_reg        <= RUN;
            drain_cnt_reg <= '0;
          end else if (drain_cnt_reg == 4'd1) begin
            st_reg        <= HALT;
            drain_cnt_reg <= '0;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - 4'd1;
          end
        end
        HALT: begin
          st_reg <= HALT;
        end
        default: begin
          st_reg        <= RUN;
          drain_cnt_reg <= '0;
        end
      endcase
    end
  end

  always_comb begin
    pc_wen      = 1'b0;
    if_id_wen   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    drain_busy  = 1'b0;
    halted      = 1'b0;
    if (rst_n) begin
      case (st_reg)
        RUN: begin
          if (flush_req) begin
            pc_wen      = 1'b1;
            if_id_wen   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (hlt_dec || stall_req) begin
            id_ex_flush = 1'b1;
          end else begin
            pc_wen    = 1'b1;
            if_id_wen = 1'b1;
          end
        end
        DRAIN: begin
          drain_busy  = 1'b1;
          id_ex_flush = 1'b1;
          // A resolved branch cancels the drain: the HLT was on the wrong path.
          if (flush_req) begin
            pc_wen      = 1'b1;
            if_id_wen   = 1'b1;
            if_id_flush = 1'b1;
          end
        end
        HALT: begin
          halted      = 1'b1;
          id_ex_flush = 1'b1;
        end
        default: begin
          id_ex_flush = 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [1:0] perf_inc;

  assign perf_inc[0] = (st_reg == RUN) && stall_req && !flush_req && !hlt_dec;
  assign perf_inc[1] = ((st_reg == RUN) || (st_reg == DRAIN)) && flush_req;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_perf
      logic [CNT_W-1:0] cnt_reg;
      // Saturating; HALT never raises perf_inc so the counters freeze there.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (perf_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign stall_cycles = g_perf[0].cnt_reg;
  assign flush_count  = g_perf[1].cnt_reg;
`else
  // CNT_W only sizes the counters; keep it referenced when they are compiled out.
  logic [31:0] unused_cnt_w;
  assign unused_cnt_w = 32'(CNT_W);
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, randomized run against a
// behavioural model, and hand-written async-reset / counter sequences.
module tb_pipe_ctrl;
  localparam int D  = 3;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall_req = 1'b0;
  logic flush_req = 1'b0;
  logic hlt_dec = 1'b0;
  logic pc_wen, if_id_wen, if_id_flush, id_ex_flush, drain_busy, halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [CW-1:0] stall_cycles, flush_count;
`endif

  pipe_ctrl #(.DRAIN_DEPTH(D), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_req   (stall_req),
    .flush_req   (flush_req),
    .hlt_dec     (hlt_dec),
    .pc_wen      (pc_wen),
    .if_id_wen   (if_id_wen),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .drain_busy  (drain_busy),
    .halted      (halted)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [5:0] outs();
    return {pc_wen, if_id_wen, if_id_flush, id_ex_flush, drain_busy, halted};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: halted flag plus number of retire edges still owed before halting.
  bit m_halted;
  int m_drain;
  int m_stalls;
  int m_flushes;
  localparam int SAT = (1 << CW) - 1;

  function automatic logic [5:0] model_out(bit r, bit s, bit f, bit h);
    bit busy;
    busy = (m_drain > 0);
    if (!r) return 6'b000000;
    if (m_halted) return 6'b000101;
    if (f) return {4'b1111, busy, 1'b0};
    if (busy || h) return {4'b0001, busy, 1'b0};
    if (s) return 6'b000100;
    return 6'b110000;
  endfunction

  task automatic model_reset();
    m_halted = 0; m_drain = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_edge(bit r, bit s, bit f, bit h);
    if (!r) model_reset();
    else if (!m_halted) begin
      if (f) begin
        if (m_flushes < SAT) m_flushes++;
        m_drain = 0;
      end else if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) m_halted = 1;
      end else if (h) begin
        m_drain = D;
      end else if (s) begin
        if (m_stalls < SAT) m_stalls++;
      end
    end
  endtask

  task automatic drive_check(input string name, input bit r, input bit s, input bit f, input bit h);
    @(negedge clk);
    rst_n = r; stall_req = s; flush_req = f; hlt_dec = h;
    #1;
    $display("%s: rst_n=%0b stall=%0b flush=%0b hlt=%0b outs=%06b", name, r, s, f, h, outs());
    chk(name, 32'(outs()), 32'(model_out(r, s, f, h)));
`ifdef PIPE_CTRL_PERF_EN
    chk({name, "_stall_cycles"}, 32'(stall_cycles), 32'(m_stalls));
    chk({name, "_flush_count"}, 32'(flush_count), 32'(m_flushes));
`endif
    @(posedge clk);
    model_edge(r, s, f, h);
  endtask

  typedef struct packed {
    logic       r, s, f, h;
    logic [5:0] exp;   // {pc_wen, if_id_wen, if_id_flush, id_ex_flush, drain_busy, halted}
  } vec_t;

  vec_t vecs [22];

  initial begin
    vecs[0]  = {4'b0000, 6'b000000};  // in reset
    vecs[1]  = {4'b1000, 6'b110000};
    vecs[2]  = {4'b1000, 6'b110000};
    vecs[3]  = {4'b1000, 6'b110000};
    vecs[4]  = {4'b1000, 6'b110000};
    vecs[5]  = {4'b1000, 6'b110000};
    vecs[6]  = {4'b1100, 6'b000100};  // stall x2
    vecs[7]  = {4'b1100, 6'b000100};
    vecs[8]  = {4'b1000, 6'b110000};
    vecs[9]  = {4'b1111, 6'b111100};  // all requests: flush wins
    vecs[10] = {4'b1000, 6'b110000};  // no drain started
    vecs[11] = {4'b1001, 6'b000100};  // HLT accepted
    vecs[12] = {4'b1000, 6'b000110};  // drain cycle 1
    vecs[13] = {4'b1010, 6'b111110};  // flush at drain cycle 2 cancels
    vecs[14] = {4'b1000, 6'b110000};
    vecs[15] = {4'b1001, 6'b000100};  // HLT at edge k
    vecs[16] = {4'b1000, 6'b000110};
    vecs[17] = {4'b1100, 6'b000110};  // stall ignored while draining
    vecs[18] = {4'b1001, 6'b000110};  // repeat HLT ignored
    vecs[19] = {4'b1000, 6'b000101};  // halted after k+3
    vecs[20] = {4'b1111, 6'b000101};
    vecs[21] = {4'b1010, 6'b000101};

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rst_n = vecs[i].r; stall_req = vecs[i].s; flush_req = vecs[i].f; hlt_dec = vecs[i].h;
      #1;
      $display("vec%0d: in=%04b outs=%06b", i, {vecs[i].r, vecs[i].s, vecs[i].f, vecs[i].h}, outs());
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      @(posedge clk);
    end

    // Sync model to the halted state reached by the table (2 stalls, 2 flushes counted).
    m_halted = 1; m_drain = 0; m_stalls = 2; m_flushes = 2;
    for (int i = 0; i < 20; i++)
      drive_check($sformatf("halt_hold%0d", i), 1'b1, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    drive_check("rst_a", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++)
      drive_check($sformatf("rnd%0d", i), 1'($urandom_range(0, 39) != 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 7) == 0));

    // Asynchronous reset in the middle of a drain.
    drive_check("rst_b", 1'b0, 1'b0, 1'b0, 1'b0);
    drive_check("mid_hlt", 1'b1, 1'b0, 1'b0, 1'b1);
    drive_check("mid_drain", 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    $display("async_rst: outs=%06b", outs());
    chk("async_rst_outs", 32'(outs()), 32'd0);
    drive_check("async_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < D + 3; i++)
      drive_check($sformatf("post_rst%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef PIPE_CTRL_PERF_EN
    drive_check("perf_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_check($sformatf("perf_stall%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) drive_check($sformatf("perf_flush%0d", i), 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; stall_req = 1'b0; flush_req = 1'b0; hlt_dec = 1'b0;
    #1;
    $display("perf_totals: stall_cycles=%0d flush_count=%0d", stall_cycles, flush_count);
    chk("perf_stall_total", 32'(stall_cycles), 32'd3);
    chk("perf_flush_total", 32'(flush_count), 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
